// File: rtl/rv32i_pkg.sv
// RV32I opcode/funct constants, ALU op encoding and the issue payload shared by the issue stage.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] ALUOP_ADD = 3'b000;
    localparam logic [2:0] ALUOP_SUB = 3'b001;
    localparam logic [2:0] ALUOP_AND = 3'b010;
    localparam logic [2:0] ALUOP_OR  = 3'b011;
    localparam logic [2:0] ALUOP_XOR = 3'b100;
    localparam logic [2:0] ALUOP_SLL = 3'b101;
    localparam logic [2:0] ALUOP_SRL = 3'b110;
    localparam logic [2:0] ALUOP_SRA = 3'b111;

    typedef struct packed {
        logic             illegal;
        logic [4:0]       rd;
        logic [2:0]       aluop;
        logic [XLEN-1:0]  b;
        logic [XLEN-1:0]  a;
    } issue_pld_t;

    localparam int PLD_W = $bits(issue_pld_t);

    function automatic logic [XLEN-1:0] sext_imm12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// Two-entry valid/ready skid buffer, 1-cycle latency, full throughput.
// in_ready is registered and low only when both main and skid slots are occupied.
module alu_issue_skid #(
    parameter int W = 73
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    skid_state_t    r_state;
    logic [W-1:0]   r_main;
    logic [W-1:0]   r_skid;
    logic           r_in_rdy;
    logic           r_out_vld;
    logic           w_in_xfer;
    logic           w_out_xfer;

    assign w_in_xfer  = in_valid & r_in_rdy;
    assign w_out_xfer = r_out_vld & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_EMPTY;
            r_main    <= '0;
            r_skid    <= '0;
            r_in_rdy  <= 1'b1;
            r_out_vld <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_main    <= in_data;
                        r_state   <= ST_ONE;
                        r_out_vld <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && !w_out_xfer) begin
                        r_skid   <= in_data;
                        r_state  <= ST_TWO;
                        r_in_rdy <= 1'b0;
                    end else if (w_out_xfer && !w_in_xfer) begin
                        r_state   <= ST_EMPTY;
                        r_out_vld <= 1'b0;
                    end else if (w_in_xfer && w_out_xfer) begin
                        r_main <= in_data;
                    end
                end
                ST_TWO: begin
                    // The older entry leaves; the skid entry becomes the head.
                    if (w_out_xfer) begin
                        r_main   <= r_skid;
                        r_state  <= ST_ONE;
                        r_in_rdy <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_EMPTY;
                    r_in_rdy  <= 1'b1;
                    r_out_vld <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_rdy;
    assign out_valid = r_out_vld;
    assign out_data  = r_main;

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: decodes in the input cycle, then holds operands in a skid buffer.
// Latency 1 cycle; in_ready is registered and drops only when two entries are held.
module alu_issue_stage
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [31:0]     in_rs1_data,
    input  logic [31:0]     in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_a,
    output logic [31:0]     out_b,
    output logic [2:0]      out_aluop,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    logic [6:0]     w_opc;
    logic [2:0]     w_f3;
    logic [6:0]     w_f7;
    logic [31:0]    w_shamt_reg;
    logic [31:0]    w_shamt_imm;
    logic [31:0]    w_a;
    logic [31:0]    w_b;
    logic [2:0]     w_aluop;
    logic           w_illegal;
    issue_pld_t     w_in_pld;
    issue_pld_t     w_out_pld;

    assign w_opc       = in_instr[6:0];
    assign w_f3        = in_instr[14:12];
    assign w_f7        = in_instr[31:25];
    assign w_shamt_reg = {27'b0, in_rs2_data[4:0]};
    assign w_shamt_imm = {27'b0, in_instr[24:20]};

    always_comb begin
        w_illegal = 1'b1;
        w_aluop   = ALUOP_ADD;
        w_a       = '0;
        w_b       = '0;
        case (w_opc)
            OPC_OP: begin
                w_a = in_rs1_data;
                w_b = in_rs2_data;
                case (w_f3)
                    F3_ADD_SUB: begin
                        if (w_f7 == F7_BASE) begin
                            w_aluop = ALUOP_ADD; w_illegal = 1'b0;
                        end else if (w_f7 == F7_ALT) begin
                            w_aluop = ALUOP_SUB; w_illegal = 1'b0;
                        end
                    end
                    F3_XOR: if (w_f7 == F7_BASE) begin w_aluop = ALUOP_XOR; w_illegal = 1'b0; end
                    F3_OR:  if (w_f7 == F7_BASE) begin w_aluop = ALUOP_OR;  w_illegal = 1'b0; end
                    F3_AND: if (w_f7 == F7_BASE) begin w_aluop = ALUOP_AND; w_illegal = 1'b0; end
                    F3_SLL: begin
                        w_b = w_shamt_reg;
                        if (w_f7 == F7_BASE) begin w_aluop = ALUOP_SLL; w_illegal = 1'b0; end
                    end
                    F3_SRL_SRA: begin
                        w_b = w_shamt_reg;
                        if (w_f7 == F7_BASE) begin
                            w_aluop = ALUOP_SRL; w_illegal = 1'b0;
                        end else if (w_f7 == F7_ALT) begin
                            w_aluop = ALUOP_SRA; w_illegal = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            OPC_OP_IMM: begin
                w_a = in_rs1_data;
                w_b = sext_imm12(in_instr[31:20]);
                case (w_f3)
                    F3_ADD_SUB: begin w_aluop = ALUOP_ADD; w_illegal = 1'b0; end
                    F3_XOR:     begin w_aluop = ALUOP_XOR; w_illegal = 1'b0; end
                    F3_OR:      begin w_aluop = ALUOP_OR;  w_illegal = 1'b0; end
                    F3_AND:     begin w_aluop = ALUOP_AND; w_illegal = 1'b0; end
                    F3_SLL: begin
                        w_b = w_shamt_imm;
                        if (w_f7 == F7_BASE) begin w_aluop = ALUOP_SLL; w_illegal = 1'b0; end
                    end
                    F3_SRL_SRA: begin
                        w_b = w_shamt_imm;
                        if (w_f7 == F7_BASE) begin
                            w_aluop = ALUOP_SRL; w_illegal = 1'b0;
                        end else if (w_f7 == F7_ALT) begin
                            w_aluop = ALUOP_SRA; w_illegal = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            OPC_LUI: begin
                w_a       = '0;
                w_b       = {in_instr[31:12], 12'b0};
                w_aluop   = ALUOP_ADD;
                w_illegal = 1'b0;
            end
            default: ;
        endcase
        // Illegal entries still issue, but with neutral operands so execute sees no stale data.
        if (w_illegal) begin
            w_a     = '0;
            w_b     = '0;
            w_aluop = ALUOP_ADD;
        end
    end

    assign w_in_pld.illegal = w_illegal;
    assign w_in_pld.rd      = in_instr[11:7];
    assign w_in_pld.aluop   = w_aluop;
    assign w_in_pld.b       = w_b;
    assign w_in_pld.a       = w_a;

    alu_issue_skid #(
        .W (PLD_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_pld),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_pld)
    );

    assign out_a       = w_out_pld.a;
    assign out_b       = w_out_pld.b;
    assign out_aluop   = w_out_pld.aluop;
    assign out_rd      = w_out_pld.rd;
    assign out_illegal = w_out_pld.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed literal checks plus a queue-based reference model of the stream.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_rs1_data = '0;
    logic [31:0] in_rs2_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_aluop;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    bit rand_rdy = 1'b0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_aluop   (out_aluop),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: classify the instruction by mnemonic, then derive operands from the ISA rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t  e;
        string mn;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        mn = "bad";
        if (opc == 7'h33) begin
            if      (f3 == 0 && f7 == 7'h00) mn = "add";
            else if (f3 == 0 && f7 == 7'h20) mn = "sub";
            else if (f3 == 4 && f7 == 7'h00) mn = "xor";
            else if (f3 == 6 && f7 == 7'h00) mn = "or";
            else if (f3 == 7 && f7 == 7'h00) mn = "and";
            else if (f3 == 1 && f7 == 7'h00) mn = "sll";
            else if (f3 == 5 && f7 == 7'h00) mn = "srl";
            else if (f3 == 5 && f7 == 7'h20) mn = "sra";
        end else if (opc == 7'h13) begin
            if      (f3 == 0) mn = "addi";
            else if (f3 == 4) mn = "xori";
            else if (f3 == 6) mn = "ori";
            else if (f3 == 7) mn = "andi";
            else if (f3 == 1 && f7 == 7'h00) mn = "slli";
            else if (f3 == 5 && f7 == 7'h00) mn = "srli";
            else if (f3 == 5 && f7 == 7'h20) mn = "srai";
        end else if (opc == 7'h37) begin
            mn = "lui";
        end
        e.rd = ins[11:7]; e.ill = 1'b0; e.a = rs1;
        case (mn)
            "add":  begin e.op = 0; e.b = rs2; end
            "sub":  begin e.op = 1; e.b = rs2; end
            "and":  begin e.op = 2; e.b = rs2; end
            "or":   begin e.op = 3; e.b = rs2; end
            "xor":  begin e.op = 4; e.b = rs2; end
            "sll":  begin e.op = 5; e.b = rs2 % 32; end
            "srl":  begin e.op = 6; e.b = rs2 % 32; end
            "sra":  begin e.op = 7; e.b = rs2 % 32; end
            "addi": begin e.op = 0; e.b = 32'($signed(ins) >>> 20); end
            "andi": begin e.op = 2; e.b = 32'($signed(ins) >>> 20); end
            "ori":  begin e.op = 3; e.b = 32'($signed(ins) >>> 20); end
            "xori": begin e.op = 4; e.b = 32'($signed(ins) >>> 20); end
            "slli": begin e.op = 5; e.b = (ins >> 20) % 32; end
            "srli": begin e.op = 6; e.b = (ins >> 20) % 32; end
            "srai": begin e.op = 7; e.b = (ins >> 20) % 32; end
            "lui":  begin e.op = 0; e.a = 0; e.b = (ins >> 12) << 12; end
            default: begin e.op = 0; e.a = 0; e.b = 0; e.ill = 1'b1; end
        endcase
        return e;
    endfunction

    // Single compare process: occupancy, head-of-queue contents and reset values each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_in_ready", 32'(in_ready), 32'd1);
                chk("rst_out_a", out_a, 32'd0);
                chk("rst_out_b", out_b, 32'd0);
                chk("rst_out_aluop", 32'(out_aluop), 32'd0);
                chk("rst_out_rd", 32'(out_rd), 32'd0);
                chk("rst_out_illegal", 32'(out_illegal), 32'd0);
            end else begin
                chk("in_ready_vs_model", 32'(in_ready), 32'(q.size() < 2));
                chk("out_valid_vs_model", 32'(out_valid), 32'(q.size() != 0));
                if (out_valid && q.size() != 0) begin
                    chk("stream_a", out_a, q[0].a);
                    chk("stream_b", out_b, q[0].b);
                    chk("stream_aluop", 32'(out_aluop), 32'(q[0].op));
                    chk("stream_rd", 32'(out_rd), 32'(q[0].rd));
                    chk("stream_illegal", 32'(out_illegal), 32'(q[0].ill));
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
                if (in_valid && in_ready)
                    q.push_back(model(in_instr, in_rs1_data, in_rs2_data));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Presents one entry and returns at posedge+1 after it was accepted.
    task automatic send(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2);
        int n;
        in_valid = 1'b1; in_instr = ins; in_rs1_data = rs1; in_rs2_data = rs2;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic expect_out(input string nm, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] op, input logic [4:0] rd, input logic ill);
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_a"}, out_a, a);
        chk({nm, "_b"}, out_b, b);
        chk({nm, "_aluop"}, 32'(out_aluop), 32'(op));
        chk({nm, "_rd"}, 32'(out_rd), 32'(rd));
        chk({nm, "_illegal"}, 32'(out_illegal), 32'(ill));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc, f7;
        logic [2:0] f3;
        int k;
        k = $urandom_range(0, 9);
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0, 1: f7 = 7'h00;
            2:    f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        if (k <= 3 || k == 9) opc = 7'h33;
        else if (k <= 6)      opc = 7'h13;
        else if (k == 7)      opc = 7'h37;
        else                  opc = 7'($urandom);
        return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), opc};
    endfunction

    initial begin
        int base;
        cycles(3);
        rst_n = 1'b1;
        cycles(2);

        send(32'h002081B3, 32'd5, 32'd7);
        expect_out("add", 32'd5, 32'd7, 3'b000, 5'd3, 1'b0);
        send(32'h40435293, 32'h8000_0000, 32'd9);
        expect_out("srai", 32'h8000_0000, 32'd4, 3'b111, 5'd5, 1'b0);
        send(32'h002091B3, 32'd1, 32'h25);
        expect_out("sll", 32'd1, 32'd5, 3'b101, 5'd3, 1'b0);
        send(32'h402081B3, 32'd10, 32'h25);
        expect_out("sub", 32'd10, 32'h25, 3'b001, 5'd3, 1'b0);
        send(32'h123450B7, 32'hDEAD_BEEF, 32'd1);
        expect_out("lui", 32'd0, 32'h1234_5000, 3'b000, 5'd1, 1'b0);
        send(32'h0020A1B3, 32'd3, 32'd4);
        expect_out("slt", 32'd0, 32'd0, 3'b000, 5'd3, 1'b1);
        send(32'hFFF00093, 32'd6, 32'd0);
        expect_out("addi_neg", 32'd6, 32'hFFFF_FFFF, 3'b000, 5'd1, 1'b0);
        cycles(2);

        // Back-pressure: two accepts fill the stage, third waits, then all drain in order.
        out_ready = 1'b0;
        base = n_out;
        send(32'h002081B3, 32'd1, 32'd0);
        send(32'h002081B3, 32'd2, 32'd0);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_instr = 32'h002081B3; in_rs1_data = 32'd3; in_rs2_data = 32'd0;
        cycles(3);
        chk("bp_in_ready_held", 32'(in_ready), 32'd0);
        expect_out("bp_hold", 32'd1, 32'd0, 3'b000, 5'd3, 1'b0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        send(32'h002081B3, 32'd3, 32'd0);
        cycles(5);
        chk("bp_drain_count", 32'(n_out - base), 32'd3);

        // Reset with two entries held.
        out_ready = 1'b0;
        send(32'h0062C2B3, 32'd11, 32'd12);
        send(32'h0062C2B3, 32'd13, 32'd14);
        chk("pre_reset_full", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 32'(out_valid), 32'd0);
        chk("async_reset_ready", 32'(in_ready), 32'd1);
        cycles(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycles(2);
        chk("post_reset_empty", 32'(out_valid), 32'd0);

        // Random valid/ready stream against the model.
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 2) == 0) cycles(1);
            send(rand_instr(), $urandom, $urandom);
        end
        rand_rdy = 1'b0;
        cycles(1);
        out_ready = 1'b1;
        cycles(6);
        chk("final_queue_empty", 32'(q.size()), 32'd0);
        chk("final_out_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
